// File: rtl/div_u16_u3_share_arb.sv
// Round-robin front end that lets REQ_N requesters share one div_u16_u3 divider.
// Winners pass through a one-entry issue register; an in-order ID FIFO steers results back.
module div_u16_u3_share_arb #(
  parameter int REQ_N         = 4,
  parameter int ID_FIFO_DEPTH = 4,
  parameter int SIM_DELAY     = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                aclken,
  input  logic [REQ_N*24-1:0] s_req_data,
  input  logic [REQ_N-1:0]    s_req_valid,
  output logic [REQ_N-1:0]    s_req_ready,
  output logic [REQ_N*24-1:0] m_rsp_data,
  output logic [REQ_N-1:0]    m_rsp_valid,
  input  logic [REQ_N-1:0]    m_rsp_ready,
  output logic [23:0]         m_div_data,
  output logic                m_div_valid,
  input  logic                m_div_ready,
  input  logic [23:0]         s_div_data,
  input  logic                s_div_valid,
  output logic                s_div_ready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid/data stay stable until that edge, and ready is never a precondition for valid.

  localparam int IDW  = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int PTRW = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(ID_FIFO_DEPTH + 1);

  logic              run;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant_id;
  logic [IDW:0]      cand;
  logic              grant_found;
  logic              grant;
  logic [23:0]       grant_data;
  logic [IDW-1:0]    rr_next;

  logic              issue_valid;
  logic [IDW-1:0]    issue_id;
  logic [23:0]       issue_data;

  logic [IDW-1:0]    id_mem [ID_FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW-1:0]   rd_ptr;
  logic [CNTW-1:0]   fifo_count;
  logic              fifo_empty;
  logic [IDW-1:0]    head_id;

  logic [CNTW:0]     inflight;
  logic              credit_ok;
  logic              div_fire;
  logic              rsp_fire;

  assign run        = aresetn & aclken;
  assign fifo_empty = (fifo_count == '0);
  assign head_id    = id_mem[rd_ptr];

  // Issue-reg occupancy counts as in flight so a full FIFO can never be overrun.
  assign inflight  = {1'b0, fifo_count} + (CNTW+1)'(issue_valid);
  assign credit_ok = (inflight < (CNTW+1)'(ID_FIFO_DEPTH));
  assign div_fire  = aclken & issue_valid & m_div_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < REQ_N; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(REQ_N)) cand = cand - (IDW+1)'(REQ_N);
      if (!grant_found && s_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand[IDW-1:0];
      end
    end
  end

  assign grant      = run & credit_ok & (~issue_valid | div_fire) & grant_found;
  assign grant_data = s_req_data[int'(grant_id)*24 +: 24];
  assign rr_next    = (grant_id == IDW'(REQ_N-1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    s_req_ready = '0;
    if (grant) s_req_ready[grant_id] = 1'b1;
  end

  assign m_div_valid = issue_valid;
  assign m_div_data  = issue_data;

  // Return path is purely combinational: the head ID selects which requester sees the result.
  assign s_div_ready = run & ~fifo_empty & m_rsp_ready[head_id];
  assign rsp_fire    = s_div_valid & s_div_ready;
  assign m_rsp_data  = {REQ_N{s_div_data}};

  always_comb begin
    m_rsp_valid = '0;
    if (run && !fifo_empty && s_div_valid) m_rsp_valid[head_id] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      issue_valid <= 1'b0;
      issue_id    <= '0;
      issue_data  <= '0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else if (aclken) begin
      if (grant) begin
        issue_valid <= 1'b1;
        issue_id    <= grant_id;
        issue_data  <= grant_data;
        rr_ptr      <= rr_next;
      end else if (div_fire) begin
        issue_valid <= 1'b0;
      end
      if (div_fire)
        wr_ptr <= (wr_ptr == PTRW'(ID_FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (rsp_fire)
        rd_ptr <= (rd_ptr == PTRW'(ID_FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (div_fire && !rsp_fire)
        fifo_count <= fifo_count + 1'b1;
      else if (!div_fire && rsp_fire)
        fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (run && div_fire) id_mem[wr_ptr] <= issue_id;
  end

  // A result with no outstanding ID means the divider and this block disagree on what is in flight.
  always_ff @(posedge aclk) begin
    if (run) begin
      assert (!(s_div_valid && fifo_empty))
        else $error("div_u16_u3_share_arb: divider result with empty ID FIFO (SIM_DELAY=%0d)", SIM_DELAY);
      assert (!(div_fire && !rsp_fire && fifo_count == CNTW'(ID_FIFO_DEPTH)))
        else $error("div_u16_u3_share_arb: ID FIFO overflow");
    end
  end

endmodule
